// File: rtl/mem_port_arbiter_if.sv
// Signal bundle tying the IF/DM requesters and the single memory port to the arbiter.
// The arbiter connects through 'master'. The pipeline and memory side connects through 'slave'.
interface mem_port_arbiter_if #(
  parameter int AW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          if_ack;

  logic          dm_req;
  logic          dm_we;
  logic          dm_byte;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic [31:0]   dm_rdata;
  logic          dm_ack;
  logic          dm_err;

  logic          mem_en;
  logic          mem_we;
  logic          mem_byte;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic          busy;

  modport master (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_byte, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_rdata, if_ack,
    output dm_rdata, dm_ack, dm_err,
    output mem_en, mem_we, mem_byte, mem_addr, mem_wdata,
    output busy
  );

  modport slave (
    output if_req, if_addr,
    output dm_req, dm_we, dm_byte, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_rdata, if_ack,
    input  dm_rdata, dm_ack, dm_err,
    input  mem_en, mem_we, mem_byte, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and the data stage.
// Data has priority, and a starvation counter forces a fetch after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] LAST_CNT   = CW'(LAT - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [AW-1:0] WORD_MASK  = ~AW'(3);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          own_dm_q, own_dm_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic          byte_q, byte_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;

  logic          pick_dm;
  logic          misaligned;

  // A pending fetch overrides data only once the starvation limit is reached.
  assign pick_dm    = bus.dm_req && !(bus.if_req && (starve_q == STARVE_LIM));
  assign misaligned = !bus.dm_byte && (bus.dm_addr[1:0] != 2'b00);

  assign bus.if_rdata = if_rdata_q;
  assign bus.dm_rdata = dm_rdata_q;
  assign bus.busy     = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      own_dm_q   <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      byte_q     <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      own_dm_q   <= own_dm_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      byte_q     <= byte_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    starve_d      = starve_q;
    own_dm_d      = own_dm_q;
    addr_d        = addr_q;
    we_d          = we_q;
    byte_d        = byte_q;
    wdata_d       = wdata_q;
    if_rdata_d    = if_rdata_q;
    dm_rdata_d    = dm_rdata_q;
    bus.if_ack    = 1'b0;
    bus.dm_ack    = 1'b0;
    bus.dm_err    = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_byte  = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_dm) begin
          own_dm_d = 1'b1;
          addr_d   = bus.dm_addr;
          we_d     = bus.dm_we;
          byte_d   = bus.dm_byte;
          wdata_d  = bus.dm_wdata;
          if (!bus.if_req) begin
            starve_d = '0;
          end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + SW'(1);
          end
          state_d = misaligned ? ERR : ACCESS;
        end else if (bus.if_req) begin
          own_dm_d = 1'b0;
          addr_d   = bus.if_addr & WORD_MASK;
          we_d     = 1'b0;
          byte_d   = 1'b0;
          wdata_d  = '0;
          starve_d = '0;
          state_d  = ACCESS;
        end
      end

      ACCESS: begin
        bus.mem_en    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_byte  = byte_q;
        bus.mem_wdata = wdata_q;
        // The write strobe fires only in the final cycle, so an aborted store never lands.
        if (cnt_q == LAST_CNT) begin
          bus.mem_we = we_q;
          if (own_dm_q) begin
            dm_rdata_d = bus.mem_rdata;
          end else begin
            if_rdata_d = bus.mem_rdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RESP: begin
        bus.if_ack = !own_dm_q;
        bus.dm_ack = own_dm_q;
        state_d    = IDLE;
      end

      ERR: begin
        bus.dm_ack = 1'b1;
        bus.dm_err = 1'b1;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at LAT=1, 2 and 3.
// Expected acks are queued when stimulus is issued and matched by negedge monitors.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.AW(32)) b1 ();
  mem_port_arbiter_if #(.AW(32)) b2 ();
  mem_port_arbiter_if #(.AW(32)) b3 ();

  mem_port_arbiter #(.LAT(1), .STARVE_MAX(4), .AW(32)) u1 (.clk(clk), .reset(reset), .bus(b1));
  mem_port_arbiter #(.LAT(2), .STARVE_MAX(4), .AW(32)) u2 (.clk(clk), .reset(reset), .bus(b2));
  mem_port_arbiter #(.LAT(3), .STARVE_MAX(4), .AW(32)) u3 (.clk(clk), .reset(reset), .bus(b3));

  function automatic logic [31:0] memval(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h801F_0020;
      32'h0000_0020: return 32'h1122_3344;
      32'h0000_0040: return 32'hCAFE_F00D;
      32'h0000_0023: return 32'h0000_00C3;
      default:       return 32'hFFFF_FFFF;
    endcase
  endfunction

  assign b1.mem_rdata = memval(b1.mem_addr);
  assign b2.mem_rdata = memval(b2.mem_addr);
  assign b3.mem_rdata = memval(b3.mem_addr);

  typedef struct {
    int          inst;
    bit          dm;
    bit          err;
    bit          chk_data;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void expect_ack(input int inst, input bit dm, input bit err,
                                     input bit chk, input logic [31:0] data, input int c);
    exp_t e;
    e.inst = inst; e.dm = dm; e.err = err; e.chk_data = chk; e.data = data; e.cyc = c;
    sb.push_back(e);
  endfunction

  function automatic void mon(input int inst, input bit dm, input logic err, input logic [31:0] data);
    int idx = -1;
    string tag;
    tag = $sformatf("u%0d_%s", inst, dm ? "dm" : "if");
    for (int i = 0; i < sb.size(); i++)
      if (idx < 0 && sb[i].inst == inst && sb[i].dm == dm) idx = i;
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_ack: got ack at cycle %0d, expected none", tag, cyc);
      return;
    end
    check({tag, "_ack_cycle"}, 32'(cyc), 32'(sb[idx].cyc));
    if (dm) check({tag, "_err"}, {31'b0, err}, {31'b0, sb[idx].err});
    if (sb[idx].chk_data) check({tag, "_rdata"}, data, sb[idx].data);
    sb.delete(idx);
  endfunction

  always @(negedge clk) begin
    if (b1.if_ack) mon(1, 1'b0, 1'b0, b1.if_rdata);
    if (b1.dm_ack) mon(1, 1'b1, b1.dm_err, b1.dm_rdata);
    if (b2.if_ack) mon(2, 1'b0, 1'b0, b2.if_rdata);
    if (b2.dm_ack) mon(2, 1'b1, b2.dm_err, b2.dm_rdata);
    if (b3.if_ack) mon(3, 1'b0, 1'b0, b3.if_rdata);
    if (b3.dm_ack) mon(3, 1'b1, b3.dm_err, b3.dm_rdata);
  end

  // Fetch requester on u1: hold if_req until n acks have been seen.
  task automatic hold_if(input logic [31:0] addr, input int n);
    int got = 0;
    int waitc = 0;
    b1.if_addr = addr;
    b1.if_req  = 1'b1;
    while (got < n && waitc < 100) begin
      @(negedge clk);
      waitc++;
      if (b1.if_ack) got++;
    end
    b1.if_req = 1'b0;
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL if_timeout: got %0d acks, expected %0d", got, n);
    end
  endtask

  // Data requester on u1: hold dm_req until n acks have been seen.
  task automatic hold_dm(input logic we, input logic bt, input logic [31:0] addr,
                         input logic [31:0] wdata, input int n);
    int got = 0;
    int waitc = 0;
    b1.dm_we    = we;
    b1.dm_byte  = bt;
    b1.dm_addr  = addr;
    b1.dm_wdata = wdata;
    b1.dm_req   = 1'b1;
    while (got < n && waitc < 100) begin
      @(negedge clk);
      waitc++;
      if (b1.dm_ack) got++;
    end
    b1.dm_req = 1'b0;
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL dm_timeout: got %0d acks, expected %0d", got, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0;
    b1.if_req = 0; b1.if_addr = '0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_byte = 0; b1.dm_addr = '0; b1.dm_wdata = '0;
    b2.if_req = 0; b2.if_addr = '0; b2.dm_req = 0; b2.dm_we = 0; b2.dm_byte = 0; b2.dm_addr = '0; b2.dm_wdata = '0;
    b3.if_req = 0; b3.if_addr = '0; b3.dm_req = 0; b3.dm_we = 0; b3.dm_byte = 0; b3.dm_addr = '0; b3.dm_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {25'b0, b1.busy, b1.mem_en, b1.mem_we, b1.mem_byte, b1.if_ack, b1.dm_ack, b1.dm_err}, 32'h0);
    check("rst_if_rdata", b1.if_rdata, 32'h0);
    check("rst_dm_rdata", b1.dm_rdata, 32'h0);
    check("rst_mem_addr", b1.mem_addr, 32'h0);
    check("rst_mem_wdata", b1.mem_wdata, 32'h0);
    check("rst_u3_busy", {31'b0, b3.busy}, 32'h0);
    reset = 1'b1;

    // Store on u3 (LAT=3) interrupted by a two-cycle reset mid-access.
    @(posedge clk); #1;
    b3.dm_we = 1'b1; b3.dm_byte = 1'b0; b3.dm_addr = 32'h2C; b3.dm_wdata = 32'h1234_5678; b3.dm_req = 1'b1;
    @(posedge clk); #1;
    check("t1_access_started", {30'b0, b3.mem_en, b3.mem_we}, 32'h2);
    reset = 1'b0;
    b3.dm_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t1_no_we_no_ack", {30'b0, b3.mem_we, b3.dm_ack}, 32'h0);
      check("t1_mem_en", {31'b0, b3.mem_en}, (k == 0) ? 32'h1 : 32'h0);
      if (k == 2) reset = 1'b1;
    end
    check("t1_busy_after", {31'b0, b3.busy}, 32'h0);

    // Plain fetches; the second one has a misaligned address that must read word 0x40.
    @(posedge clk); #1;
    n = cyc;
    expect_ack(1, 1'b0, 1'b0, 1'b1, 32'h801F_0020, n + 2);
    hold_if(32'h0, 1);
    @(posedge clk); #1;
    n = cyc;
    expect_ack(1, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, n + 2);
    hold_if(32'h42, 1);

    // Simultaneous requests: data first, fetch LAT+2 cycles later.
    @(posedge clk); #1;
    n = cyc;
    expect_ack(1, 1'b1, 1'b0, 1'b1, 32'h1122_3344, n + 2);
    expect_ack(1, 1'b0, 1'b0, 1'b1, 32'h801F_0020, n + 5);
    fork
      hold_dm(1'b0, 1'b0, 32'h20, 32'h0, 1);
      hold_if(32'h0, 1);
    join

    // Continuous data traffic: four data grants, forced fetch, then data again.
    @(posedge clk); #1;
    n = cyc;
    for (int i = 0; i < 4; i++) expect_ack(1, 1'b1, 1'b0, 1'b1, 32'h1122_3344, n + 2 + 3 * i);
    expect_ack(1, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, n + 14);
    expect_ack(1, 1'b1, 1'b0, 1'b1, 32'h1122_3344, n + 17);
    fork
      hold_dm(1'b0, 1'b0, 32'h20, 32'h0, 5);
      hold_if(32'h40, 1);
    join

    // Misaligned word load: error ack next cycle, no memory cycle, rdata unchanged.
    @(posedge clk); #1;
    n = cyc;
    expect_ack(1, 1'b1, 1'b1, 1'b1, 32'h1122_3344, n + 1);
    fork
      hold_dm(1'b0, 1'b0, 32'h22, 32'h0, 1);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("t5_err_no_mem_en", {31'b0, b1.mem_en}, 32'h0);
        end
      end
    join

    // Byte store at the same odd address is legal.
    @(posedge clk); #1;
    n = cyc;
    expect_ack(1, 1'b1, 1'b0, 1'b0, 32'h0, n + 2);
    fork
      hold_dm(1'b1, 1'b1, 32'h22, 32'hAB, 1);
      begin
        @(negedge clk);
        @(negedge clk);
        check("t5_sb_en_we_byte", {29'b0, b1.mem_en, b1.mem_we, b1.mem_byte}, 32'h7);
        check("t5_sb_addr", b1.mem_addr, 32'h22);
        check("t5_sb_wdata", b1.mem_wdata, 32'hAB);
      end
    join

    // Byte load returns the raw memory word.
    @(posedge clk); #1;
    n = cyc;
    expect_ack(1, 1'b1, 1'b0, 1'b1, 32'h0000_00C3, n + 2);
    hold_dm(1'b0, 1'b1, 32'h23, 32'h0, 1);

    // Word store on u2 (LAT=2): two enable cycles, write strobe only on the second.
    @(posedge clk); #1;
    n = cyc;
    expect_ack(2, 1'b1, 1'b0, 1'b0, 32'h0, n + 3);
    b2.dm_we = 1'b1; b2.dm_byte = 1'b0; b2.dm_addr = 32'h2C; b2.dm_wdata = 32'h5; b2.dm_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_en_we", {30'b0, b2.mem_en, b2.mem_we},
            (k == 1) ? 32'h2 : ((k == 2) ? 32'h3 : 32'h0));
      if (k == 2) check("t6_wdata", b2.mem_wdata, 32'h5);
    end
    b2.dm_req = 1'b0;

    // Word load on u2.
    @(posedge clk); #1;
    n = cyc;
    expect_ack(2, 1'b1, 1'b0, 1'b1, 32'h1122_3344, n + 3);
    b2.dm_we = 1'b0; b2.dm_addr = 32'h20; b2.dm_req = 1'b1;
    repeat (4) @(negedge clk);
    b2.dm_req = 1'b0;

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
